// File: rtl/branch_flag_comparator_pkg.sv
// Shared types and constants for the chunk-serial branch flag comparator.
// Holds the flag bit positions, the FSM state encoding and the default sizes.
package branch_flag_comparator_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;
  localparam int unsigned FLAGS_W   = 3;

  localparam int unsigned FLAG_EQ  = 2;
  localparam int unsigned FLAG_LT  = 1;
  localparam int unsigned FLAG_LTU = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/branch_flag_comparator_if.sv
// Start/busy/done handshake plus operands and the ALUFlags result.
// The master requests comparisons; the slave is the comparator.
interface branch_flag_comparator_if
  import branch_flag_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic               Start;
  logic [WIDTH-1:0]   Src1;
  logic [WIDTH-1:0]   Src2;
  logic               Busy;
  logic               Done;
  logic [FLAGS_W-1:0] ALUFlags;

  modport master (output Start, Src1, Src2, input Busy, Done, ALUFlags);
  modport slave  (input Start, Src1, Src2, output Busy, Done, ALUFlags);
endinterface

// File: rtl/branch_flag_comparator_chunk_compare.sv
// Combinational compare of one CHUNK-bit operand slice.
// Reports whether the slices differ and whether a < b unsigned.
module chunk_compare
  import branch_flag_comparator_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             neq,
  output logic             ltu
);
  assign neq = (a != b);
  assign ltu = (a < b);
endmodule

// File: rtl/branch_flag_comparator.sv
// Multi-cycle branch flag comparator: walks the operands MSB chunk first,
// stops at the first differing chunk and registers {eq, lt, ltu}.
module branch_flag_comparator
  import branch_flag_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input logic                     CLK,
  input logic                     RESET,
  branch_flag_comparator_if.slave bus
);

  localparam int unsigned N     = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("branch_flag_comparator: CHUNK must be nonzero and divide WIDTH");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic               busy_q, done_q;

  logic               neq, ltu, lt;
  logic [FLAGS_W-1:0] result;

  // Operands are shifted left each step, so the active chunk is always on top.
  chunk_compare #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_q[WIDTH-1 -: CHUNK]),
    .b   (b_q[WIDTH-1 -: CHUNK]),
    .neq (neq),
    .ltu (ltu)
  );

  // Top bits are the true sign bits only at idx 0; a sign mismatch always ends there.
  assign lt = (idx_q == '0 && a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : ltu;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
      busy_q  <= (state_d == ST_COMPARE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
    result  = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          state_d = ST_COMPARE;
          idx_d   = '0;
          a_d     = bus.Src1;
          b_d     = bus.Src2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (neq || idx_q == LAST_IDX) begin
          if (neq) begin
            result[FLAG_LT]  = lt;
            result[FLAG_LTU] = ltu;
          end else begin
            result[FLAG_EQ]  = 1'b1;
          end
          flags_d = result;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.ALUFlags = flags_q;

endmodule

// File: tb/tb_branch_flag_comparator.sv
// Directed bench for branch_flag_comparator: vector table plus reset,
// ignored-start and back-to-back sequences.
module tb_branch_flag_comparator;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_flag_comparator_if #(.WIDTH(32)) bus ();

  branch_flag_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    int          done_cyc;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Start in cycle 0 from IDLE, then watch for the Done pulse.
  task automatic run_op(input string name, input logic [31:0] s1, input logic [31:0] s2,
                        input int exp_cyc, input logic [2:0] exp_flags);
    int done_cyc = 0;
    int busy_cnt = 0;
    int overlap  = 0;
    logic [2:0] got_flags = 3'b000;
    bus.Start = 1'b1;
    bus.Src1  = s1;
    bus.Src2  = s2;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        bus.Start = 1'b0;
        bus.Src1  = ~s1;
        bus.Src2  = ~s2;
      end
      if (bus.Busy && bus.Done) overlap++;
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        done_cyc  = c;
        got_flags = bus.ALUFlags;
        break;
      end
    end
    check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({name, " flags"}, 32'(got_flags), 32'(exp_flags));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc - 1));
    check({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
    step();
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    logic [2:0] f1;
    logic [2:0] f2;
    int unstable;

    vecs[0] = '{32'h12345678, 32'h12345678, 5, 3'b100};
    vecs[1] = '{32'h80000000, 32'h00000001, 2, 3'b010};
    vecs[2] = '{32'h00000005, 32'h00000007, 5, 3'b011};
    vecs[3] = '{32'hFFFF0000, 32'hFFFFFFFF, 4, 3'b011};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFF0000, 4, 3'b000};
    vecs[5] = '{32'h00000001, 32'h80000000, 2, 3'b001};
    vecs[6] = '{32'h12000000, 32'h11FFFFFF, 2, 3'b000};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 2, 3'b010};
    vecs[8] = '{32'h00001200, 32'h00001300, 4, 3'b011};
    vecs[9] = '{32'h00000000, 32'h00000000, 5, 3'b100};

    RESET     = 1'b1;
    bus.Start = 1'b0;
    bus.Src1  = '0;
    bus.Src2  = '0;
    step();
    step();
    RESET = 1'b0;
    check("reset busy", 32'(bus.Busy), 32'd0);
    check("reset done", 32'(bus.Done), 32'd0);
    check("reset flags", 32'(bus.ALUFlags), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].src1, vecs[i].src2, vecs[i].done_cyc, vecs[i].flags);
    end

    // Start pulses while busy are neither queued nor disturb the latched operands.
    bus.Start = 1'b1;
    bus.Src1  = 32'h12345678;
    bus.Src2  = 32'h12345678;
    done_cyc  = 0;
    f1        = 3'b000;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        bus.Src1 = 32'h00000000;
        bus.Src2 = 32'h00000001;
      end
      if (c == 3) bus.Start = 1'b0;
      if (bus.Done) begin
        done_cyc = c;
        f1       = bus.ALUFlags;
        break;
      end
    end
    check("ignored_start done_cycle", 32'(done_cyc), 32'd5);
    check("ignored_start flags", 32'(f1), 32'(3'b100));
    step();
    check("ignored_start idle busy", 32'(bus.Busy), 32'd0);
    check("ignored_start idle done", 32'(bus.Done), 32'd0);
    step();

    // Reset mid-compare aborts without a Done and clears the flags.
    bus.Start = 1'b1;
    bus.Src1  = 32'h12345678;
    bus.Src2  = 32'h12345678;
    step();
    check("abort busy c1", 32'(bus.Busy), 32'd1);
    step();
    bus.Start = 1'b0;
    RESET     = 1'b1;
    step();
    RESET = 1'b0;
    check("abort busy c3", 32'(bus.Busy), 32'd0);
    check("abort flags c3", 32'(bus.ALUFlags), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.Done) done_cnt++;
      step();
    end
    check("abort no done", 32'(done_cnt), 32'd0);

    // Start coincident with reset is dropped.
    bus.Start = 1'b1;
    RESET     = 1'b1;
    step();
    bus.Start = 1'b0;
    RESET     = 1'b0;
    check("start_in_reset busy", 32'(bus.Busy), 32'd0);
    step();
    check("start_in_reset busy2", 32'(bus.Busy), 32'd0);

    // Back-to-back with Start held high.
    bus.Start = 1'b1;
    bus.Src1  = 32'h5;
    bus.Src2  = 32'h7;
    done_cnt  = 0;
    done_cyc  = 0;
    f1        = 3'b111;
    f2        = 3'b111;
    unstable  = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) begin
        bus.Src1 = 32'h7;
        bus.Src2 = 32'h5;
      end
      if (bus.Done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          check("b2b first done_cycle", 32'(c), 32'd5);
          f1 = bus.ALUFlags;
        end else begin
          done_cyc = c;
          f2       = bus.ALUFlags;
          bus.Start = 1'b0;
          break;
        end
      end else if (done_cnt == 1 && bus.ALUFlags !== f1) begin
        unstable++;
      end
    end
    check("b2b second done_cycle", 32'(done_cyc), 32'd10);
    check("b2b flags1", 32'(f1), 32'(3'b011));
    check("b2b flags2", 32'(f2), 32'(3'b000));
    check("b2b flags stable", 32'(unstable), 32'd0);
    step();
    step();
    check("b2b end idle", 32'(bus.Busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
